// File: rtl/bus_pkg.sv
// Shared bus definitions: control-bus bit positions, master FSM states and default widths.
package bus_pkg;

   localparam int unsigned BUS_WIDTH_DEF  = 32;
   localparam int unsigned CTRL_WIDTH_DEF = 8;
   localparam int unsigned TIMEOUT_DEF    = 255;
   localparam int unsigned BURST_WIDTH    = 3;

   localparam int unsigned CTRL_WAIT      = 0;
   localparam int unsigned CTRL_WE        = 1;
   localparam int unsigned CTRL_BURST_LSB = 2;
   localparam int unsigned CTRL_BURST_MSB = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ADDR,
      TURN,
      DATA,
      REL
   } mst_state_t;

   // Address-phase control word: WAIT low, WE and BURST set, reserved bits zero.
   function automatic logic [CTRL_WIDTH_DEF-1:0] ctrl_addr_phase(
      input logic                   we,
      input logic [BURST_WIDTH-1:0] burst
   );
      logic [CTRL_WIDTH_DEF-1:0] w;
      w                                = '0;
      w[CTRL_WE]                       = we;
      w[CTRL_BURST_MSB:CTRL_BURST_LSB] = burst;
      return w;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall watchdog: clear/enable cycle counter that flags the TIMEOUT-th consecutive stalled cycle.
module bus_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;

   // Terminal count is raised during the stalled cycle that completes TIMEOUT stalls.
   assign o_tc_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/bus_master_if.sv
// Master-side bus port: runs request/address/turnaround/data/release for one client burst,
// streaming write beats out, returning read beats, and aborting on a stall timeout.
module bus_master_if
   import bus_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = BUS_WIDTH_DEF,
   parameter int unsigned CTRL_WIDTH = CTRL_WIDTH_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_start,
   input  logic [BUS_WIDTH-1:0]   cmd_addr,
   input  logic                   cmd_we,
   input  logic [BURST_WIDTH-1:0] cmd_burst,
   output logic                   cmd_busy,
   output logic                   cmd_done,
   output logic                   cmd_err,
   input  logic [BUS_WIDTH-1:0]   wr_data,
   output logic                   wr_pop,
   output logic [BUS_WIDTH-1:0]   rd_data,
   output logic                   rd_valid,
   output logic                   req,
   input  logic                   ack,
   output logic [CTRL_WIDTH-1:0]  ctrl_in,
   output logic [BUS_WIDTH-1:0]   bus_in,
   input  logic [CTRL_WIDTH-1:0]  ctrl_out,
   input  logic [BUS_WIDTH-1:0]   bus_out
);

   mst_state_t             r_state;
   mst_state_t             w_next;

   logic [BUS_WIDTH-1:0]   r_addr;
   logic                   r_we;
   logic [BURST_WIDTH-1:0] r_burst;
   logic [BURST_WIDTH-1:0] r_beat;
   logic                   r_rel_last;

   logic                   r_req;
   logic [CTRL_WIDTH-1:0]  r_ctrl_in;
   logic [BUS_WIDTH-1:0]   r_bus_in;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic [BUS_WIDTH-1:0]   r_rd_data;
   logic                   r_rd_valid;

   logic                   w_req_d;
   logic [CTRL_WIDTH-1:0]  w_ctrl_d;
   logic [BUS_WIDTH-1:0]   w_bus_d;
   logic                   w_done_d;
   logic                   w_err_d;
   logic                   w_beat_done;
   logic                   w_last_beat;
   logic                   w_wd_en;
   logic                   w_wd_clr;
   logic                   w_wd_tc;
   logic                   w_unused_ctrl;

   assign w_unused_ctrl = ^ctrl_out[CTRL_WIDTH-1:1];

   assign w_beat_done = (r_state == DATA) && !ctrl_out[CTRL_WAIT];
   assign w_last_beat = w_beat_done && (r_beat == r_burst);
   assign w_wd_en     = ((r_state == REQ) && !ack) ||
                        ((r_state == DATA) && ctrl_out[CTRL_WAIT]);
   assign w_wd_clr    = (w_next != r_state) || w_beat_done;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_wd_clr),
      .i_en    (w_wd_en),
      .o_tc_c  (w_wd_tc)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state plus next values of the registered outputs, decoded from the state being entered.
   always_comb begin
      w_next   = r_state;
      w_req_d  = 1'b0;
      w_ctrl_d = '0;
      w_bus_d  = '0;
      w_done_d = 1'b0;
      w_err_d  = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (cmd_start) w_next = REQ;
         end
         REQ: begin
            if (ack) begin
               w_next = ADDR;
            end else if (w_wd_tc) begin
               w_next  = REL;
               w_err_d = 1'b1;
            end
         end
         ADDR: w_next = TURN;
         TURN: w_next = DATA;
         DATA: begin
            if (w_last_beat) begin
               w_next   = REL;
               w_done_d = 1'b1;
            end else if (w_wd_tc) begin
               w_next  = REL;
               w_err_d = 1'b1;
            end
         end
         REL: begin
            if (r_rel_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase

      w_req_d = (w_next == REQ) || (w_next == ADDR) || (w_next == TURN) || (w_next == DATA);
      if (w_next == ADDR) begin
         w_bus_d  = r_addr;
         w_ctrl_d = CTRL_WIDTH'(ctrl_addr_phase(r_we, r_burst));
      end
   end

   // Command latch, beat counter and release sequencing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_burst    <= '0;
         r_beat     <= '0;
         r_rel_last <= 1'b0;
      end else begin
         if ((r_state == IDLE) && cmd_start) begin
            r_addr  <= cmd_addr;
            r_we    <= cmd_we;
            r_burst <= cmd_burst;
         end
         if (r_state != DATA) begin
            r_beat <= '0;
         end else if (w_beat_done) begin
            r_beat <= r_beat + BURST_WIDTH'(1);
         end
         r_rel_last <= (r_state == REL) && !r_rel_last;
      end
   end

   // Registered outputs and read-beat capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req      <= 1'b0;
         r_ctrl_in  <= '0;
         r_bus_in   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_req      <= w_req_d;
         r_ctrl_in  <= w_ctrl_d;
         r_bus_in   <= w_bus_d;
         r_busy     <= (w_next != IDLE);
         r_done     <= w_done_d;
         r_err      <= w_err_d;
         r_rd_valid <= w_beat_done && !r_we;
         if (w_beat_done && !r_we) begin
            r_rd_data <= bus_out;
         end
      end
   end

   // Write beats must reach the bus and pop in the same cycle the slave drops WAIT.
   assign wr_pop   = w_beat_done && r_we;
   assign bus_in   = ((r_state == DATA) && r_we) ? wr_data : r_bus_in;

   assign req      = r_req;
   assign ctrl_in  = r_ctrl_in;
   assign cmd_busy = r_busy;
   assign cmd_done = r_done;
   assign cmd_err  = r_err;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: write, read burst, stalled write, request timeout, reset abort.
module tb_bus_master_if;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_start;
   logic [31:0] cmd_addr;
   logic        cmd_we;
   logic [2:0]  cmd_burst;
   logic        cmd_busy;
   logic        cmd_done;
   logic        cmd_err;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        req;
   logic        ack;
   logic [7:0]  ctrl_in;
   logic [31:0] bus_in;
   logic [7:0]  ctrl_out;
   logic [31:0] bus_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bus_master_if #(
      .BUS_WIDTH  (32),
      .CTRL_WIDTH (8),
      .TIMEOUT    (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_start (cmd_start),
      .cmd_addr  (cmd_addr),
      .cmd_we    (cmd_we),
      .cmd_burst (cmd_burst),
      .cmd_busy  (cmd_busy),
      .cmd_done  (cmd_done),
      .cmd_err   (cmd_err),
      .wr_data   (wr_data),
      .wr_pop    (wr_pop),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .req       (req),
      .ack       (ack),
      .ctrl_in   (ctrl_in),
      .bus_in    (bus_in),
      .ctrl_out  (ctrl_out),
      .bus_out   (bus_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive point just after the rising edge; check point at the falling edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic start_cmd(input logic [31:0] a, input logic we, input logic [2:0] b);
      cmd_start = 1'b1;
      cmd_addr  = a;
      cmd_we    = we;
      cmd_burst = b;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd_vals [4];
      logic        wait_pat [5];
      int          pops;
      int          n;
      logic        saw_done;

      rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33; rd_vals[3] = 32'h44;
      wait_pat[0] = 1'b0; wait_pat[1] = 1'b1; wait_pat[2] = 1'b1;
      wait_pat[3] = 1'b1; wait_pat[4] = 1'b0;

      reset_n   = 1'b0;
      cmd_start = 1'b0;
      cmd_addr  = '0;
      cmd_we    = 1'b0;
      cmd_burst = '0;
      wr_data   = '0;
      ack       = 1'b0;
      ctrl_out  = '0;
      bus_out   = '0;

      // Reset state
      repeat (2) cyc();
      mid();
      chk("rst_req", req, 0);
      chk("rst_busy", cmd_busy, 0);
      chk("rst_done_err", {cmd_done, cmd_err}, 0);
      chk("rst_pop_valid", {wr_pop, rd_valid}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_bus_in", bus_in, 0);
      chk("rst_ctrl_in", ctrl_in, 0);
      cyc();
      reset_n = 1'b1;
      ack     = 1'b1;
      mid();
      cyc();
      mid();
      chk("idle_ack_ignored", req, 0);
      cyc();
      ack = 1'b0;

      // Single write, ack on third REQ cycle
      start_cmd(32'h0000_1000, 1'b1, 3'd0);
      wr_data = 32'hDEAD_BEEF;
      mid();
      chk("w1_busy_idle", cmd_busy, 0);
      cyc();
      cmd_start = 1'b0;
      mid();
      chk("w1_req", req, 1);
      chk("w1_busy", cmd_busy, 1);
      cyc();
      mid();
      chk("w1_req_wait", req, 1);
      cyc();
      ack = 1'b1;
      mid();
      cyc();
      ack = 1'b0;
      mid();
      chk("w1_addr_bus", bus_in, 32'h1000);
      chk("w1_addr_ctrl", ctrl_in, 32'h02);
      chk("w1_addr_req", req, 1);
      cyc();
      mid();
      chk("w1_turn_bus", bus_in, 0);
      chk("w1_turn_pop", wr_pop, 0);
      chk("w1_turn_ctrl", ctrl_in, 0);
      cyc();
      mid();
      chk("w1_data_pop", wr_pop, 1);
      chk("w1_data_bus", bus_in, 32'hDEAD_BEEF);
      chk("w1_data_done", cmd_done, 0);
      cyc();
      mid();
      chk("w1_rel1_req", req, 0);
      chk("w1_rel1_done", cmd_done, 1);
      chk("w1_rel1_pop", wr_pop, 0);
      chk("w1_rel1_bus", bus_in, 0);
      chk("w1_rel1_busy", cmd_busy, 1);
      cyc();
      mid();
      chk("w1_rel2_req", req, 0);
      chk("w1_rel2_done", cmd_done, 0);
      chk("w1_rel2_busy", cmd_busy, 1);
      cyc();
      mid();
      chk("w1_idle_busy", cmd_busy, 0);

      // Read burst of 4
      cyc();
      start_cmd(32'h0000_2000, 1'b0, 3'd3);
      ack = 1'b1;
      cyc();
      cmd_start = 1'b0;
      mid();
      chk("r4_req", req, 1);
      cyc();
      ack = 1'b0;
      mid();
      chk("r4_addr_ctrl", ctrl_in, 32'h0C);
      chk("r4_addr_bus", bus_in, 32'h2000);
      cyc();
      for (int i = 0; i < 4; i++) begin
         cyc();
         bus_out = rd_vals[i];
         mid();
         chk("r4_data_bus_in", bus_in, 0);
         chk("r4_data_pop", wr_pop, 0);
         if (i == 0) begin
            chk("r4_valid0", rd_valid, 0);
         end else begin
            chk("r4_valid", rd_valid, 1);
            chk("r4_rd_data", rd_data, rd_vals[i-1]);
         end
      end
      cyc();
      bus_out = '0;
      mid();
      chk("r4_last_valid", rd_valid, 1);
      chk("r4_last_data", rd_data, 32'h44);
      chk("r4_done", cmd_done, 1);
      chk("r4_rel_req", req, 0);
      cyc();
      mid();
      chk("r4_rel2_valid", rd_valid, 0);
      chk("r4_rel2_busy", cmd_busy, 1);
      cyc();
      mid();
      chk("r4_idle_busy", cmd_busy, 0);

      // Stalled write, two beats with 3 WAIT cycles between
      cyc();
      start_cmd(32'h0000_3000, 1'b1, 3'd1);
      wr_data = 32'hA0A0_A0A0;
      ack     = 1'b1;
      cyc();
      cmd_start = 1'b0;
      cyc();
      ack = 1'b0;
      cyc();
      pops = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         ctrl_out = {7'd0, wait_pat[i]};
         if (i == 1) wr_data = 32'hB1B1_B1B1;
         mid();
         chk("sw_pop", wr_pop, {31'd0, !wait_pat[i]});
         chk("sw_done_in_data", cmd_done, 0);
         if (wr_pop) pops++;
         if (i == 0) chk("sw_beat0", bus_in, 32'hA0A0_A0A0);
         if (i == 4) chk("sw_beat1", bus_in, 32'hB1B1_B1B1);
      end
      cyc();
      ctrl_out = '0;
      mid();
      chk("sw_pop_count", pops, 2);
      chk("sw_done", cmd_done, 1);
      chk("sw_err", cmd_err, 0);
      repeat (2) cyc();
      mid();
      chk("sw_idle_busy", cmd_busy, 0);

      // Request timeout, ack never given
      cyc();
      start_cmd(32'h0000_4000, 1'b0, 3'd0);
      cyc();
      cmd_start = 1'b0;
      n        = 0;
      saw_done = 1'b0;
      mid();
      while (req && n < 40) begin
         n++;
         if (cmd_done || cmd_err) saw_done = 1'b1;
         cyc();
         mid();
      end
      chk("wd_req_cycles", n, 8);
      chk("wd_err", cmd_err, 1);
      chk("wd_no_done", {cmd_done, saw_done}, 0);
      cyc();
      mid();
      chk("wd_rel2_busy", cmd_busy, 1);
      chk("wd_rel2_err", cmd_err, 0);
      cyc();
      mid();
      chk("wd_idle_busy", cmd_busy, 0);

      // Start while busy is ignored, then reset mid-DATA
      cyc();
      start_cmd(32'h0000_5000, 1'b1, 3'd7);
      wr_data  = 32'h5555_5555;
      ack      = 1'b1;
      ctrl_out = 8'h01;
      cyc();
      start_cmd(32'h0000_BAD0, 1'b0, 3'd2);
      mid();
      chk("rb_req", req, 1);
      cyc();
      cmd_start = 1'b0;
      ack       = 1'b0;
      mid();
      chk("rb_first_addr", bus_in, 32'h5000);
      chk("rb_first_ctrl", ctrl_in, 32'h1E);
      cyc();
      cyc();
      mid();
      chk("rb_stall_pop", wr_pop, 0);
      cyc();
      ctrl_out = 8'h00;
      mid();
      chk("rb_pop_before_rst", wr_pop, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rb_async_req", req, 0);
      chk("rb_async_pop", wr_pop, 0);
      chk("rb_async_valid", rd_valid, 0);
      chk("rb_async_busy", cmd_busy, 0);
      chk("rb_async_bus", bus_in, 0);
      chk("rb_async_done_err", {cmd_done, cmd_err}, 0);
      cyc();
      mid();
      chk("rb_hold_done_err", {cmd_done, cmd_err}, 0);
      cyc();
      reset_n = 1'b1;
      mid();
      cyc();
      mid();
      chk("rb_no_queue_req", req, 0);
      chk("rb_no_queue_busy", cmd_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
